// File: rtl/axi_err_slv.sv
// AXI4 error slave: accepts every write and read transaction, discards write data,
// and answers each with ERR_RESP (and a fixed read data pattern on every R beat).
module axi_err_slv #(
   parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
   parameter int unsigned AXI4_DATA_WIDTH    = 32,
   parameter int unsigned AXI4_ID_WIDTH      = 16,
   parameter int unsigned AXI4_USER_WIDTH    = 10,
   parameter int unsigned AXI_STRB_WIDTH     = AXI4_DATA_WIDTH / 32'd8,
   parameter logic [1:0]  ERR_RESP           = 2'b11,
   parameter logic [31:0] RDATA_PATTERN      = 32'hBADC_AB1E
) (
   input  logic                          ACLK,
   input  logic                          ARESETn,
   input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
   input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
   input  logic [7:0]                    AWLEN_i,
   input  logic [2:0]                    AWSIZE_i,
   input  logic [1:0]                    AWBURST_i,
   input  logic                          AWLOCK_i,
   input  logic [3:0]                    AWCACHE_i,
   input  logic [2:0]                    AWPROT_i,
   input  logic [3:0]                    AWREGION_i,
   input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
   input  logic [3:0]                    AWQOS_i,
   input  logic                          AWVALID_i,
   output logic                          AWREADY_o,
   input  logic [AXI4_DATA_WIDTH-1:0]    WDATA_i,
   input  logic [AXI_STRB_WIDTH-1:0]     WSTRB_i,
   input  logic                          WLAST_i,
   input  logic [AXI4_USER_WIDTH-1:0]    WUSER_i,
   input  logic                          WVALID_i,
   output logic                          WREADY_o,
   output logic [AXI4_ID_WIDTH-1:0]      BID_o,
   output logic [1:0]                    BRESP_o,
   output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
   output logic                          BVALID_o,
   input  logic                          BREADY_i,
   input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
   input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
   input  logic [7:0]                    ARLEN_i,
   input  logic [2:0]                    ARSIZE_i,
   input  logic [1:0]                    ARBURST_i,
   input  logic                          ARLOCK_i,
   input  logic [3:0]                    ARCACHE_i,
   input  logic [2:0]                    ARPROT_i,
   input  logic [3:0]                    ARREGION_i,
   input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
   input  logic [3:0]                    ARQOS_i,
   input  logic                          ARVALID_i,
   output logic                          ARREADY_o,
   output logic [AXI4_ID_WIDTH-1:0]      RID_o,
   output logic [AXI4_DATA_WIDTH-1:0]    RDATA_o,
   output logic [1:0]                    RRESP_o,
   output logic                          RLAST_o,
   output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
   output logic                          RVALID_o,
   input  logic                          RREADY_i
);

   localparam logic [AXI4_DATA_WIDTH-1:0] RDATA_VAL = AXI4_DATA_WIDTH'(RDATA_PATTERN);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   w_state_t                     w_state_r, w_state_nxt_s;
   r_state_t                     r_state_r, r_state_nxt_s;
   logic [AXI4_ID_WIDTH-1:0]     bid_r, bid_nxt_s, rid_r, rid_nxt_s;
   logic [7:0]                   cnt_r, cnt_nxt_s;
   logic                         awready_r, wready_r, bvalid_r;
   logic                         arready_r, rvalid_r, rlast_r;
   logic [1:0]                   bresp_r, rresp_r;
   logic [AXI4_DATA_WIDTH-1:0]   rdata_r;
   logic                         aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
   logic                         unused_s;

   assign aw_hs_s = AWVALID_i & awready_r;
   assign w_hs_s  = WVALID_i  & wready_r;
   assign b_hs_s  = bvalid_r  & BREADY_i;
   assign ar_hs_s = ARVALID_i & arready_r;
   assign r_hs_s  = rvalid_r  & RREADY_i;

   // Write path next-state: address capture, data drain until WLAST, then response.
   always_comb begin
      w_state_nxt_s = w_state_r;
      bid_nxt_s     = bid_r;
      case (w_state_r)
         W_IDLE: begin
            if (aw_hs_s) begin
               w_state_nxt_s = W_DATA;
               bid_nxt_s     = AWID_i;
            end else begin
               w_state_nxt_s = W_IDLE;
            end
         end
         W_DATA: begin
            if (w_hs_s && WLAST_i) begin
               w_state_nxt_s = W_RESP;
            end else begin
               w_state_nxt_s = W_DATA;
            end
         end
         W_RESP: begin
            if (b_hs_s) begin
               w_state_nxt_s = W_IDLE;
            end else begin
               w_state_nxt_s = W_RESP;
            end
         end
         default: w_state_nxt_s = W_IDLE;
      endcase
   end

   // Write path state and registered channel outputs, decoded from the next state.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state_r <= W_IDLE;
         bid_r     <= '0;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         bresp_r   <= 2'b00;
      end else begin
         w_state_r <= w_state_nxt_s;
         bid_r     <= bid_nxt_s;
         awready_r <= (w_state_nxt_s == W_IDLE);
         wready_r  <= (w_state_nxt_s == W_DATA);
         bvalid_r  <= (w_state_nxt_s == W_RESP);
         bresp_r   <= (w_state_nxt_s == W_RESP) ? ERR_RESP : 2'b00;
      end
   end

   // Read path next-state: the beat counter saturates at zero, so ARLEN 255 yields 256 beats.
   always_comb begin
      r_state_nxt_s = r_state_r;
      rid_nxt_s     = rid_r;
      cnt_nxt_s     = cnt_r;
      case (r_state_r)
         R_IDLE: begin
            if (ar_hs_s) begin
               r_state_nxt_s = R_DATA;
               rid_nxt_s     = ARID_i;
               cnt_nxt_s     = ARLEN_i;
            end else begin
               r_state_nxt_s = R_IDLE;
            end
         end
         R_DATA: begin
            if (r_hs_s && (cnt_r == 8'd0)) begin
               r_state_nxt_s = R_IDLE;
            end else if (r_hs_s) begin
               cnt_nxt_s = cnt_r - 8'd1;
            end else begin
               r_state_nxt_s = R_DATA;
            end
         end
         default: r_state_nxt_s = R_IDLE;
      endcase
   end

   // Read path state and registered channel outputs, decoded from the next state.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state_r <= R_IDLE;
         rid_r     <= '0;
         cnt_r     <= 8'd0;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= '0;
         rresp_r   <= 2'b00;
         rlast_r   <= 1'b0;
      end else begin
         r_state_r <= r_state_nxt_s;
         rid_r     <= rid_nxt_s;
         cnt_r     <= cnt_nxt_s;
         arready_r <= (r_state_nxt_s == R_IDLE);
         rvalid_r  <= (r_state_nxt_s == R_DATA);
         rdata_r   <= (r_state_nxt_s == R_DATA) ? RDATA_VAL : '0;
         rresp_r   <= (r_state_nxt_s == R_DATA) ? ERR_RESP : 2'b00;
         rlast_r   <= (r_state_nxt_s == R_DATA) && (cnt_nxt_s == 8'd0);
      end
   end

   assign AWREADY_o = awready_r;
   assign WREADY_o  = wready_r;
   assign BVALID_o  = bvalid_r;
   assign BID_o     = bid_r;
   assign BRESP_o   = bresp_r;
   assign BUSER_o   = '0;
   assign ARREADY_o = arready_r;
   assign RVALID_o  = rvalid_r;
   assign RID_o     = rid_r;
   assign RDATA_o   = rdata_r;
   assign RRESP_o   = rresp_r;
   assign RLAST_o   = rlast_r;
   assign RUSER_o   = '0;

   // Transaction attributes and payload carry no meaning for an error responder.
   assign unused_s = ^{AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i, AWLOCK_i, AWCACHE_i, AWPROT_i,
                       AWREGION_i, AWUSER_i, AWQOS_i, WDATA_i, WSTRB_i, WUSER_i,
                       ARADDR_i, ARSIZE_i, ARBURST_i, ARLOCK_i, ARCACHE_i, ARPROT_i,
                       ARREGION_i, ARUSER_i, ARQOS_i};

endmodule

// File: tb/tb_axi_err_slv.sv
// Self-checking bench for axi_err_slv: scenario tasks with a scoreboard of expected
// B and R beats, sampled one time unit after each rising clock edge.
module tb_axi_err_slv;

   typedef struct packed {
      logic [15:0] id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [9:0]  user;
   } rbeat_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [15:0] awid = 16'd0, arid = 16'd0, bid, rid;
   logic [31:0] awaddr = 32'd0, araddr = 32'd0, wdata = 32'd0, rdata;
   logic [7:0]  awlen = 8'd0, arlen = 8'd0;
   logic [3:0]  wstrb = 4'd0;
   logic [9:0]  awuser = 10'd0, aruser = 10'd0, wuser = 10'd0, buser, ruser;
   logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [1:0]  bresp, rresp;

   rbeat_t      r_q[$];
   logic [15:0] b_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 aclk = ~aclk;

   axi_err_slv dut (
      .ACLK(aclk), .ARESETn(aresetn),
      .AWID_i(awid), .AWADDR_i(awaddr), .AWLEN_i(awlen), .AWSIZE_i(3'd2), .AWBURST_i(2'b01),
      .AWLOCK_i(1'b0), .AWCACHE_i(4'd0), .AWPROT_i(3'd0), .AWREGION_i(4'd0), .AWUSER_i(awuser),
      .AWQOS_i(4'd0), .AWVALID_i(awvalid), .AWREADY_o(awready),
      .WDATA_i(wdata), .WSTRB_i(wstrb), .WLAST_i(wlast), .WUSER_i(wuser), .WVALID_i(wvalid),
      .WREADY_o(wready),
      .BID_o(bid), .BRESP_o(bresp), .BUSER_o(buser), .BVALID_o(bvalid), .BREADY_i(bready),
      .ARID_i(arid), .ARADDR_i(araddr), .ARLEN_i(arlen), .ARSIZE_i(3'd2), .ARBURST_i(2'b01),
      .ARLOCK_i(1'b0), .ARCACHE_i(4'd0), .ARPROT_i(3'd0), .ARREGION_i(4'd0), .ARUSER_i(aruser),
      .ARQOS_i(4'd0), .ARVALID_i(arvalid), .ARREADY_o(arready),
      .RID_o(rid), .RDATA_o(rdata), .RRESP_o(rresp), .RLAST_o(rlast), .RUSER_o(ruser),
      .RVALID_o(rvalid), .RREADY_i(rready)
   );

   task automatic push_read(input logic [15:0] id, input int len);
      for (int i = 0; i <= len; i++) begin
         r_q.push_back({id, 32'hBADC_AB1E, 2'b11, (i == len), 10'd0});
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      logic [126:0] outs;
      repeat (2) @(posedge aclk);
      #1;
      outs = {awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid};
      checks++;
      if (outs !== 127'd0) begin
         errors++; $display("FAIL reset_outputs got %h exp 0", outs);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      checks++;
      if ({awready, arready} !== 2'b00) begin
         errors++; $display("FAIL ready_before_edge got %b exp 00", {awready, arready});
      end
      tick();
      checks++;
      if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
         errors++; $display("FAIL ready_after_reset got %b exp 11000", {awready, arready, wready, bvalid, rvalid});
      end
   endtask

   task automatic test_single_write();
      logic [15:0] eb;
      awid = 16'h0012; awaddr = $urandom(); awvalid = 1'b1; bready = 1'b1;
      b_q.push_back(16'h0012);
      checks++;
      if (awready !== 1'b1) begin errors++; $display("FAIL wr_awready got %b exp 1", awready); end
      tick();
      awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1; wdata = $urandom(); wstrb = 4'hF;
      checks++;
      if ({awready, wready} !== 2'b01) begin errors++; $display("FAIL wr_wready got %b exp 01", {awready, wready}); end
      tick();
      wvalid = 1'b0; wlast = 1'b0;
      checks++;
      if ({bvalid, wready} !== 2'b10) begin errors++; $display("FAIL wr_bvalid_latency got %b exp 10", {bvalid, wready}); end
      if (bvalid && bready) begin
         eb = b_q.pop_front();
         checks++;
         if ({bid, bresp, buser} !== {eb, 2'b11, 10'd0}) begin
            errors++; $display("FAIL wr_bpayload got %h/%b/%h exp %h/11/000", bid, bresp, buser, eb);
         end
      end
      tick();
      bready = 1'b0;
      checks++;
      if ({bvalid, awready, b_q.size() == 0} !== 3'b011) begin
         errors++; $display("FAIL wr_complete got %b exp 011", {bvalid, awready, b_q.size() == 0});
      end
   endtask

   task automatic test_read_burst();
      rbeat_t obs, held, exp_b;
      int     nb = 0;
      bit     stalled = 1'b0;
      logic   pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      arid = 16'h0005; arlen = 8'd3; araddr = $urandom(); arvalid = 1'b1;
      push_read(16'h0005, 3);
      checks++;
      if (arready !== 1'b1) begin errors++; $display("FAIL rd_arready got %b exp 1", arready); end
      tick();
      arvalid = 1'b0;
      checks++;
      if ({rvalid, arready} !== 2'b10) begin errors++; $display("FAIL rd_latency got %b exp 10", {rvalid, arready}); end
      for (int c = 0; c < 20 && nb < 4; c++) begin
         rready = (c < 5) ? pat[c] : 1'b1;
         obs = {rid, rdata, rresp, rlast, ruser};
         if (stalled) begin
            stalled = 1'b0;
            checks++;
            if (obs !== held) begin errors++; $display("FAIL rd_stable got %h exp %h", obs, held); end
         end
         if (rvalid && rready) begin
            exp_b = r_q.pop_front();
            nb++;
            checks++;
            if (obs !== exp_b) begin errors++; $display("FAIL rd_beat%0d got %h exp %h", nb, obs, exp_b); end
         end else if (rvalid) begin
            held = obs; stalled = 1'b1;
         end
         tick();
      end
      rready = 1'b0;
      checks++;
      if ({nb == 4, rvalid, arready} !== 3'b101) begin
         errors++; $display("FAIL rd_done beats %0d rvalid %b arready %b exp 4 0 1", nb, rvalid, arready);
      end
   endtask

   task automatic test_long_burst();
      rbeat_t obs, exp_b;
      int     nb = 0;
      arid = 16'hA5A5; arlen = 8'd255; arvalid = 1'b1;
      push_read(16'hA5A5, 255);
      tick();
      arvalid = 1'b0; rready = 1'b1;
      for (int c = 0; c < 300 && nb < 256; c++) begin
         obs = {rid, rdata, rresp, rlast, ruser};
         if (rvalid) begin
            exp_b = r_q.pop_front();
            nb++;
            checks++;
            if (obs !== exp_b) begin errors++; $display("FAIL long_beat%0d got %h exp %h", nb, obs, exp_b); end
         end
         tick();
      end
      rready = 1'b0;
      checks++;
      if ({nb == 256, rvalid, arready} !== 3'b101) begin
         errors++; $display("FAIL long_done beats %0d rvalid %b arready %b exp 256 0 1", nb, rvalid, arready);
      end
   endtask

   task automatic test_concurrent();
      rbeat_t obs, exp_b;
      logic [15:0] eb;
      int nb = 0, wb = 0, bstall = 0;
      bit bdone = 1'b0;
      awid = 16'h003A; awvalid = 1'b1; arid = 16'h0007; arlen = 8'd1; arvalid = 1'b1;
      b_q.push_back(16'h003A);
      push_read(16'h0007, 1);
      checks++;
      if ({awready, arready} !== 2'b11) begin errors++; $display("FAIL conc_ready got %b exp 11", {awready, arready}); end
      tick();
      awvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if ({awready, arready} !== 2'b00) begin errors++; $display("FAIL conc_both_taken got %b exp 00", {awready, arready}); end
      for (int c = 0; c < 40 && !(bdone && nb == 2); c++) begin
         wvalid = (wb < 2); wlast = (wb == 1); wdata = $urandom();
         rready = 1'b1; bready = (bstall >= 5);
         obs = {rid, rdata, rresp, rlast, ruser};
         if (rvalid && rready) begin
            exp_b = r_q.pop_front();
            nb++;
            checks++;
            if (obs !== exp_b) begin errors++; $display("FAIL conc_rbeat%0d got %h exp %h", nb, obs, exp_b); end
         end
         if (wvalid && wready) wb++;
         if (!bvalid && bstall > 0 && !bdone) begin
            checks++; errors++; $display("FAIL conc_bvalid_dropped got 0 exp 1 after %0d stalls", bstall);
         end
         if (bvalid && !bready) begin
            bstall++;
            checks++;
            if ({bid, bresp} !== {16'h003A, 2'b11}) begin
               errors++; $display("FAIL conc_bhold got %h/%b exp 003a/11", bid, bresp);
            end
         end else if (bvalid && bready) begin
            eb = b_q.pop_front();
            bdone = 1'b1;
            checks++;
            if ({bid, bresp, buser} !== {eb, 2'b11, 10'd0}) begin
               errors++; $display("FAIL conc_bpayload got %h/%b exp %h/11", bid, bresp, eb);
            end
         end
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0; rready = 1'b0; bready = 1'b0;
      checks++;
      if ({nb == 2, wb == 2, bdone, bstall == 5} !== 4'b1111) begin
         errors++; $display("FAIL conc_done rbeats %0d wbeats %0d bdone %b bstall %0d exp 2 2 1 5", nb, wb, bdone, bstall);
      end
   endtask

   task automatic test_w_before_aw();
      logic [15:0] eb;
      wvalid = 1'b1; wlast = 1'b1; wdata = $urandom();
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (wready !== 1'b0) begin errors++; $display("FAIL early_w_held%0d got %b exp 0", c, wready); end
         tick();
      end
      awid = 16'h0044; awvalid = 1'b1; b_q.push_back(16'h0044);
      checks++;
      if ({wready, awready} !== 2'b01) begin errors++; $display("FAIL early_w_aw got %b exp 01", {wready, awready}); end
      tick();
      awvalid = 1'b0;
      checks++;
      if (wready !== 1'b1) begin errors++; $display("FAIL early_w_open got %b exp 1", wready); end
      tick();
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      checks++;
      if (bvalid !== 1'b1) begin
         errors++; $display("FAIL early_w_bvalid got %b exp 1", bvalid);
      end else begin
         eb = b_q.pop_front();
         checks++;
         if (bid !== eb) begin errors++; $display("FAIL early_w_bid got %h exp %h", bid, eb); end
      end
      tick();
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0) begin errors++; $display("FAIL early_w_bdone got %b exp 0", bvalid); end
   endtask

   task automatic test_reset_mid_burst();
      rbeat_t obs, exp_b;
      int nb = 0;
      arid = 16'h0009; arlen = 8'd7; arvalid = 1'b1;
      push_read(16'h0009, 7);
      tick();
      arvalid = 1'b0; rready = 1'b1;
      obs = {rid, rdata, rresp, rlast, ruser};
      exp_b = r_q.pop_front();
      checks++;
      if (!rvalid || obs !== exp_b) begin errors++; $display("FAIL rst_beat1 got %b/%h exp 1/%h", rvalid, obs, exp_b); end
      tick();
      checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL rst_beat2_valid got %b exp 1", rvalid); end
      aresetn = 1'b0;
      r_q.delete();
      #1;
      checks++;
      if ({rvalid, rlast, arready, rid} !== 19'd0) begin
         errors++; $display("FAIL rst_async_drop got %b%b%b/%h exp 000/0000", rvalid, rlast, arready, rid);
      end
      rready = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      tick();
      checks++;
      if ({arready, rvalid} !== 2'b10) begin errors++; $display("FAIL rst_recover got %b exp 10", {arready, rvalid}); end
      arid = 16'h0001; arlen = 8'd0; arvalid = 1'b1;
      push_read(16'h0001, 0);
      tick();
      arvalid = 1'b0; rready = 1'b1;
      for (int c = 0; c < 10 && r_q.size() != 0; c++) begin
         obs = {rid, rdata, rresp, rlast, ruser};
         if (rvalid) begin
            exp_b = r_q.pop_front();
            nb++;
            checks++;
            if (obs !== exp_b) begin errors++; $display("FAIL rst_single got %h exp %h", obs, exp_b); end
         end
         tick();
      end
      rready = 1'b0;
      checks++;
      if ({nb == 1, rvalid, arready} !== 3'b101) begin
         errors++; $display("FAIL rst_single_done beats %0d rvalid %b arready %b exp 1 0 1", nb, rvalid, arready);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_burst();
      test_long_burst();
      test_concurrent();
      test_w_before_aw();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
